// File: rtl/hex2dec_pkg.sv
// rtl/hex2dec_pkg.sv - shared types and helpers for the sequential binary-to-BCD converter
package hex2dec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Decimal digits needed to hold 2^width-1: ceil(width*log10(2)), log10(2) ~ 0.30103.
  function automatic int min_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/hex2dec_seq_if.sv
// rtl/hex2dec_seq_if.sv - handshake, result and display bus of the hex2dec_seq converter
interface hex2dec_seq_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic                  convert;
  logic [IN_W-1:0]       hex;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;
  logic [4*DIGITS-1:0]   out;

  modport master (
    output start, convert, hex,
    input  busy, done, ovf, neg, bcd, out
  );

  modport slave (
    input  start, convert, hex,
    output busy, done, ovf, neg, bcd, out
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble correction of one BCD digit (>=5 gets +3)
module bcd_digit_adj
  import hex2dec_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/hex2dec_seq.sv
// rtl/hex2dec_seq.sv - one-bit-per-clock double-dabble converter with display mux
// Optional build macro SIGNED_EN: treat hex as two's complement and convert its magnitude.
module hex2dec_seq
  import hex2dec_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5,
  parameter int AUTO   = 0
) (
  input  logic          clk,
  input  logic          reset,
  hex2dec_seq_if.slave  bus
);

  localparam int OUT_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam bit OVF_POSSIBLE = (DIGITS < min_digits(IN_W));

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [IN_W-1:0]    r_bin;
  logic [OUT_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_bcd;
  logic               r_ovf_acc;
  logic               r_neg_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic               r_neg;
  logic               w_load;
  logic               w_last;
  logic               w_carry;
  logic               w_ovf_next;
  logic               w_sign;
  logic [IN_W-1:0]    w_mag;
  logic [OUT_W-1:0]   w_adj;
  logic [OUT_W-1:0]   w_shift;
  logic [OUT_W-1:0]   w_hex_ext;

`ifdef SIGNED_EN
  // Negating the most-negative value wraps to itself, which reads as 2^(IN_W-1) unsigned.
  assign w_sign = bus.hex[IN_W-1];
  assign w_mag  = w_sign ? -bus.hex : bus.hex;
`else
  assign w_sign = 1'b0;
  assign w_mag  = bus.hex;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // Adjusted accumulator and binary register shift left together; the top bit falls out as carry.
  assign {w_carry, w_shift} = {w_adj, r_bin[IN_W-1]};
  assign w_ovf_next         = r_ovf_acc | (OVF_POSSIBLE & w_carry);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if ((AUTO != 0) || bus.start) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_bin     <= '0;
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
      r_neg_acc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_neg     <= 1'b0;
      r_bcd     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_bin     <= w_mag;
        r_acc     <= '0;
        r_ovf_acc <= 1'b0;
        r_neg_acc <= w_sign;
        r_cnt     <= CNT_W'(IN_W);
        r_busy    <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_bin     <= r_bin << 1;
        r_acc     <= w_shift;
        r_ovf_acc <= w_ovf_next;
        r_cnt     <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_bcd  <= w_shift;
          r_ovf  <= w_ovf_next;
          r_neg  <= r_neg_acc;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  if (OUT_W > IN_W) begin : g_hex_ext
    assign w_hex_ext = {{(OUT_W - IN_W){1'b0}}, bus.hex};
  end else if (OUT_W == IN_W) begin : g_hex_same
    assign w_hex_ext = bus.hex;
  end else begin : g_hex_trunc
    assign w_hex_ext = bus.hex[OUT_W-1:0];
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;
  assign bus.neg  = r_neg;
  assign bus.bcd  = r_bcd;
  assign bus.out  = bus.convert ? r_bcd : w_hex_ext;

endmodule

// File: tb/tb_hex2dec_seq.sv
// tb/tb_hex2dec_seq.sv - randomized and directed checks of hex2dec_seq against an arithmetic reference
module tb_hex2dec_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hex2dec_seq_if #(.IN_W(16), .DIGITS(5)) if5 ();
  hex2dec_seq_if #(.IN_W(16), .DIGITS(4)) if4 ();
  hex2dec_seq_if #(.IN_W(16), .DIGITS(5)) ifa ();

  hex2dec_seq #(.IN_W(16), .DIGITS(5), .AUTO(0)) u5 (.clk(clk), .reset(reset), .bus(if5));
  hex2dec_seq #(.IN_W(16), .DIGITS(4), .AUTO(0)) u4 (.clk(clk), .reset(reset), .bus(if4));
  hex2dec_seq #(.IN_W(16), .DIGITS(5), .AUTO(1)) ua (.clk(clk), .reset(reset), .bus(ifa));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decimal reference: value mod 10^d as packed digits, plus overflow and sign.
  function automatic void model(input logic [15:0] v, input int d,
                                output logic [19:0] b, output logic o, output logic n);
    longint mag, lim, m;
    mag = longint'(v);
    n   = 1'b0;
`ifdef SIGNED_EN
    if (v[15]) begin
      n   = 1'b1;
      mag = 65536 - longint'(v);
    end
`endif
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    o = (mag >= lim);
    m = mag % lim;
    b = '0;
    for (int i = 0; i < d; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  task automatic run_conv(input logic [15:0] v);
    logic [19:0] e5, e4;
    logic        o5, o4, n5, n4, cv;
    int          lat;
    model(v, 5, e5, o5, n5);
    model(v, 4, e4, o4, n4);
    @(negedge clk);
    if5.hex = v; if4.hex = v; if5.start = 1'b1; if4.start = 1'b1;
    @(posedge clk); #1;
    if5.start = 1'b0; if4.start = 1'b0;
    if5.hex = 16'($urandom); if4.hex = if5.hex;
    chk("busy_after_start", 32'(if5.busy), 32'd1);
    lat = 0;
    while (!if5.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin
        if5.start = 1'b1; if4.start = 1'b1;
        if5.hex = 16'($urandom); if4.hex = if5.hex;
      end else begin
        if5.start = 1'b0; if4.start = 1'b0;
      end
    end
    if5.start = 1'b0; if4.start = 1'b0;
    chk("latency", 32'(lat), 32'd16);
    chk("done4_aligned", 32'(if4.done), 32'd1);
    chk("bcd5", 32'(if5.bcd), 32'(e5));
    chk("ovf5", 32'(if5.ovf), 32'(o5));
    chk("neg5", 32'(if5.neg), 32'(n5));
    chk("bcd4", 32'(if4.bcd), 32'(e4[15:0]));
    chk("ovf4", 32'(if4.ovf), 32'(o4));
    chk("neg4", 32'(if4.neg), 32'(n4));
    chk("busy_at_done", 32'(if5.busy), 32'd0);
    cv = 1'($urandom);
    if5.convert = cv; if4.convert = cv;
    #1;
    chk("out5_mux", 32'(if5.out), cv ? 32'(e5) : 32'(if5.hex));
    chk("out4_mux", 32'(if4.out), cv ? 32'(e4[15:0]) : 32'(if4.hex));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(if5.done), 32'd0);
    chk("bcd5_hold", 32'(if5.bcd), 32'(e5));
  endtask

  task automatic wait_auto_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ifa.done && n < 60);
  endtask

  initial begin
    logic [15:0] dir [8];
    logic [19:0] ea;
    logic        oa, na;
    int          n, dones;

    dir = '{16'hFFFF, 16'h1234, 16'h0009, 16'h00FF, 16'h8000, 16'h7FFF, 16'h0000, 16'h0001};
    if5.start = 1'b0; if5.convert = 1'b1; if5.hex = '0;
    if4.start = 1'b0; if4.convert = 1'b1; if4.hex = '0;
    ifa.start = 1'b0; ifa.convert = 1'b1; ifa.hex = 16'd100;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(if5.busy), 32'd0);
    chk("rst_done", 32'(if5.done), 32'd0);
    chk("rst_ovf", 32'(if5.ovf), 32'd0);
    chk("rst_neg", 32'(if5.neg), 32'd0);
    chk("rst_bcd", 32'(if5.bcd), 32'd0);
    chk("rst_out", 32'(if5.out), 32'd0);
    chk("rst_auto_busy", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_conv(dir[i]);
    for (int i = 0; i < 12; i++) run_conv(16'($urandom));

    run_conv(16'h00FF);
    @(negedge clk);
    if5.convert = 1'b1; #1;
    chk("out_bcd_00ff", 32'(if5.out), 32'h00255);
    if5.convert = 1'b0; if4.convert = 1'b0;
    if5.hex = 16'hABCD; if4.hex = 16'hABCD;
    #1;
    chk("out_pass5", 32'(if5.out), 32'h0ABCD);
    chk("out_pass4", 32'(if4.out), 32'h0ABCD);
    chk("pass_bcd_kept", 32'(if5.bcd), 32'h00255);
    chk("pass_idle", 32'(if5.busy), 32'd0);

    @(negedge clk);
    if5.hex = 16'h1234; if4.hex = 16'h1234; if5.start = 1'b1; if4.start = 1'b1;
    @(posedge clk); #1;
    if5.start = 1'b0; if4.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if5.start = 1'b1; if4.start = 1'b1;
    @(posedge clk); #1;
    if5.start = 1'b0; if4.start = 1'b0;
    @(posedge clk); #1;
    chk("busy_mid", 32'(if5.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(if5.busy), 32'd0);
    chk("abort_bcd", 32'(if5.bcd), 32'd0);
    chk("abort_ovf", 32'(if5.ovf), 32'd0);
    chk("abort_done", 32'(if5.done), 32'd0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (if5.done || if4.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_bcd_later", 32'(if5.bcd), 32'd0);

    model(16'd100, 5, ea, oa, na);
    wait_auto_done(n);
    chk("auto_first_done_seen", 32'(ifa.done), 32'd1);
    wait_auto_done(n);
    chk("auto_period", 32'(n), 32'd17);
    chk("auto_bcd_100", 32'(ifa.bcd), 32'(ea));
    chk("auto_ovf", 32'(ifa.ovf), 32'(oa));
    @(posedge clk); #1;
    ifa.hex = 16'd7;
    wait_auto_done(n);
    chk("auto_period_mid", 32'(n + 1), 32'd17);
    chk("auto_bcd_running", 32'(ifa.bcd), 32'(ea));
    model(16'd7, 5, ea, oa, na);
    wait_auto_done(n);
    chk("auto_period_next", 32'(n), 32'd17);
    chk("auto_bcd_7", 32'(ifa.bcd), 32'(ea));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
